// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core: word/register typedefs,
// control encodings and the ID/EX pipeline bundle.
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALUOP_W = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    SRC_RDAT2  = 2'b00,
    SRC_EXTOUT = 2'b01,
    SRC_SHAMT  = 2'b10
  } alusrc_t;

  typedef enum logic [1:0] {
    DST_RT  = 2'b00,
    DST_RD  = 2'b01,
    DST_R31 = 2'b10
  } regdst_t;

  typedef struct packed {
    logic     valid;
    word_t    pc4;
    word_t    rdat1;
    word_t    rdat2;
    word_t    extout;
    regbits_t rs;
    regbits_t rt;
    regbits_t rd;
    regbits_t shamt;
    aluop_t   aluop;
    alusrc_t  alusrc;
    regdst_t  regdst;
    logic     regwen;
    logic     memren;
    logic     memwen;
    logic     memtoreg;
    logic     jal;
    logic     halt;
  } id_ex_t;

  // All-zero bundle: no register or memory write, not valid.
  localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/id_ex_if.sv
// ID/EX pipeline interface shared by the latch, the EX stage and the
// hazard/forwarding unit.
interface id_ex_if;
  import cpu_types_pkg::*;

  logic   flush;
  logic   stall;
  logic   bubble;
  id_ex_t id;
  id_ex_t ex;
  logic   frozen;

  modport latch (
    input  flush, stall, bubble, id,
    output ex, frozen
  );

  modport ex_stage (
    input ex, frozen
  );

  modport hazard (
    output flush, stall, bubble,
    input  ex, frozen
  );

endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with flush/stall/bubble control and a sticky
// halt freeze that only reset releases.
//
// state  | meaning
// RUN    | normal pipeline operation
// HALTED | valid halt reached EX; contents held until reset
module id_ex_latch
  import cpu_types_pkg::*;
(
  input logic  CLK,
  input logic  nRST,
  id_ex_if.latch bus
);

  localparam logic RUN    = 1'b0;
  localparam logic HALTED = 1'b1;

  logic   state;
  id_ex_t ex_r;
  id_ex_t cap;

  // Invalid slots keep their data but must never commit side effects.
  always_comb begin
    cap = bus.id;
    if (!bus.id.valid) begin
      cap.regwen = 1'b0;
      cap.memren = 1'b0;
      cap.memwen = 1'b0;
      cap.halt   = 1'b0;
      cap.jal    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_r  <= ID_EX_NOP;
      state <= RUN;
    end else if (bus.flush) begin
      ex_r <= ID_EX_NOP;
    end else if (state == HALTED || bus.stall) begin
      ex_r <= ex_r;
    end else if (bus.bubble) begin
      ex_r <= ID_EX_NOP;
    end else begin
      ex_r <= cap;
      if (bus.id.valid && bus.id.halt) state <= HALTED;
    end
  end

  assign bus.ex     = ex_r;
  assign bus.frozen = (state == HALTED);

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed-vector scoreboard bench for the ID/EX pipeline latch.
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  id_ex_if bus ();

  id_ex_latch dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    id_ex_t ex;
    logic   frozen;
    string  name;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;

  // Monitor: one expected bundle per edge, compared on the falling edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.ex !== e.ex || bus.frozen !== e.frozen) begin
        errors++;
        $display("FAIL %s: got ex=%h frozen=%b, want ex=%h frozen=%b",
                 e.name, bus.ex, bus.frozen, e.ex, e.frozen);
      end
    end
  end

  task automatic cyc(input logic fl, input logic st, input logic bu,
                     input id_ex_t d, input id_ex_t exp_ex,
                     input logic exp_fz, input string nm);
    exp_t e;
    @(negedge CLK);
    #1;
    bus.flush  = fl;
    bus.stall  = st;
    bus.bubble = bu;
    bus.id     = d;
    e.ex = exp_ex; e.frozen = exp_fz; e.name = nm;
    sb.push_back(e);
    @(posedge CLK);
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (bus.ex !== ID_EX_NOP || bus.frozen !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ex=%h frozen=%b, want all zero", nm, bus.ex, bus.frozen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  id_ex_t addiu, lw, add_i, junk, inv, inv_exp, halt_i, nop;

  initial begin
    nop = ID_EX_NOP;

    addiu = '0;
    addiu.valid = 1'b1; addiu.pc4 = 32'h0000_0104; addiu.rdat1 = 32'h0000_0010;
    addiu.extout = 32'hFFFF_FFFC; addiu.rs = 5'd4; addiu.rt = 5'd8;
    addiu.aluop = ALU_ADD; addiu.alusrc = SRC_EXTOUT; addiu.regdst = DST_RT;
    addiu.regwen = 1'b1;

    lw = '0;
    lw.valid = 1'b1; lw.pc4 = 32'h0000_0108; lw.rdat1 = 32'h7FFF_EFF0;
    lw.extout = 32'h0000_0004; lw.rs = 5'd29; lw.rt = 5'd9;
    lw.aluop = ALU_ADD; lw.alusrc = SRC_EXTOUT; lw.regdst = DST_RT;
    lw.regwen = 1'b1; lw.memren = 1'b1; lw.memtoreg = 1'b1;

    add_i = '0;
    add_i.valid = 1'b1; add_i.pc4 = 32'h0000_010C; add_i.rdat1 = 32'h1111_1111;
    add_i.rdat2 = 32'h2222_2222; add_i.rs = 5'd9; add_i.rt = 5'd10; add_i.rd = 5'd11;
    add_i.aluop = ALU_ADD; add_i.alusrc = SRC_RDAT2; add_i.regdst = DST_RD;
    add_i.regwen = 1'b1;

    junk = '0;
    junk.valid = 1'b1; junk.pc4 = 32'hAAAA_0000; junk.rdat1 = 32'h5A5A_5A5A;
    junk.rd = 5'd31; junk.regdst = DST_R31; junk.jal = 1'b1; junk.regwen = 1'b1;
    junk.aluop = ALU_OR;

    inv = '0;
    inv.valid = 1'b0; inv.pc4 = 32'h0000_0110; inv.rdat2 = 32'hDEAD_BEEF;
    inv.rs = 5'd3; inv.rt = 5'd5; inv.extout = 32'h0000_0020;
    inv.memwen = 1'b1; inv.regwen = 1'b1; inv.memren = 1'b1; inv.jal = 1'b1;
    inv.halt = 1'b1; inv.memtoreg = 1'b1; inv.aluop = ALU_ADD; inv.alusrc = SRC_EXTOUT;
    inv_exp = inv;
    inv_exp.memwen = 1'b0; inv_exp.regwen = 1'b0; inv_exp.memren = 1'b0;
    inv_exp.jal = 1'b0; inv_exp.halt = 1'b0;

    halt_i = '0;
    halt_i.valid = 1'b1; halt_i.halt = 1'b1; halt_i.pc4 = 32'h0000_0200;
    halt_i.rdat1 = 32'hCAFE_0001;

    nRST = 1'b0;
    bus.flush = 1'b0; bus.stall = 1'b0; bus.bubble = 1'b0; bus.id = addiu;
    @(posedge CLK); #1;
    chk_zero("reset_hold");
    @(negedge CLK); #1;
    nRST = 1'b1;

    cyc(0, 0, 0, addiu, addiu, 0, "addiu_capture");
    junk.pc4 = 32'hAAAA_0001; cyc(0, 1, 0, junk, addiu, 0, "stall_1");
    junk.pc4 = 32'hAAAA_0002; cyc(0, 1, 0, junk, addiu, 0, "stall_2");
    junk.pc4 = 32'hAAAA_0003; cyc(0, 1, 0, junk, addiu, 0, "stall_3");
    cyc(1, 1, 0, junk, nop, 0, "flush_over_stall");

    cyc(0, 0, 0, lw, lw, 0, "lw_capture");
    cyc(0, 0, 1, add_i, nop, 0, "bubble_nop");
    cyc(0, 0, 0, add_i, add_i, 0, "add_after_bubble");
    cyc(0, 1, 1, junk, add_i, 0, "bubble_ignored_in_stall");

    cyc(0, 0, 0, inv, inv_exp, 0, "invalid_capture");
    cyc(1, 0, 0, halt_i, nop, 0, "flush_beats_halt");

    cyc(0, 0, 0, halt_i, halt_i, 1, "halt_capture");
    for (int i = 0; i < 5; i++) begin
      id_ex_t d;
      d = junk;
      d.pc4   = 32'h0000_0300 + 32'(4 * i);
      d.rdat1 = 32'(i + 1);
      d.aluop = aluop_t'(4'(i));
      d.halt  = (i == 2);
      cyc(0, 0, 0, d, halt_i, 1, "frozen_hold");
    end
    cyc(1, 0, 0, addiu, nop, 1, "flush_while_frozen");
    cyc(0, 0, 0, addiu, nop, 1, "frozen_after_flush");

    @(negedge CLK); #1;
    nRST = 1'b0;
    #1;
    chk_zero("reset_clears_frozen");
    @(negedge CLK); #1;
    nRST = 1'b1;

    cyc(0, 0, 0, lw, lw, 0, "run_after_reset");
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    chk_zero("async_reset_midcycle");
    @(negedge CLK); #1;
    nRST = 1'b1;
    cyc(0, 0, 0, add_i, add_i, 0, "capture_after_release");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
